// File: rtl/rf_burst_reader.sv
// rf_burst_reader: streams bursts read from a register file's combinational
// read port through a 2-entry output buffer with valid/ready backpressure.
module rf_burst_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [ADDR_WIDTH-1:0] i_req_len,
    output logic [ADDR_WIDTH-1:0] o_rf_raddr,
    input  logic [DATA_WIDTH-1:0] i_rf_rdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [ADDR_WIDTH-1:0] o_rsp_addr,
    output logic                  o_rsp_last,
    output logic                  o_busy
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [DATA_WIDTH-1:0] r_data [2];
    logic [ADDR_WIDTH-1:0] r_addr [2];
    logic                  r_last [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic   w_pop;
    logic   w_push;
    logic   w_accept;
    state_t w_next;

    assign w_pop    = o_rsp_valid & i_rsp_ready;
    // A full buffer can still take a beat when its head leaves on the same edge
    assign w_push   = (r_state == READ) && (r_count != 2'd2 || w_pop);
    assign w_accept = i_req_valid & r_req_ready;

    assign o_req_ready = r_req_ready;
    assign o_busy      = r_busy;
    assign o_rf_raddr  = (r_state == READ) ? r_cur_addr : '0;
    assign o_rsp_valid = r_count != 2'd0;
    assign o_rsp_data  = r_data[r_rptr];
    assign o_rsp_addr  = r_addr[r_rptr];
    assign o_rsp_last  = r_last[r_rptr];

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_accept)
            w_next = READ;
        else if (r_state == READ && w_push && r_remaining == '0)
            w_next = DRAIN;
        else if (r_state == DRAIN && w_pop && r_count == 2'd1)
            w_next = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_addr[i] <= '0;
                r_last[i] <= 1'b0;
            end
        end else begin
            r_state     <= w_next;
            r_req_ready <= w_next == IDLE;
            r_busy      <= w_next != IDLE;
            if (w_accept) begin
                r_cur_addr  <= i_req_addr;
                r_remaining <= i_req_len;
            end else if (w_push) begin
                r_cur_addr  <= r_cur_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_push) begin
                r_data[r_wptr] <= i_rf_rdata;
                r_addr[r_wptr] <= r_cur_addr;
                r_last[r_wptr] <= r_remaining == '0;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule
